// File: rtl/uart_rx_if.sv
// Receive-side bus of the UART receiver: the received byte, its strobes and a busy flag.
// data_valid / frame_err are one-cycle strobes with no ready: the consumer must capture data_out on the strobe cycle.
interface uart_rx_if;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  modport master (output data_out, output data_valid, output frame_err, output busy);
  modport slave  (input  data_out, input  data_valid, input  frame_err, input  busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, oversampling tick generator and a
// START/DATA/STOP FSM that samples every bit at mid-bit.
module uart_rx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 2400,
  parameter int OVERSAMPLE = 16
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        rx,
  uart_rx_if.master   bus,
  output logic [1:0]  dbg_state
);

  localparam int TICK_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW       = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);

  generate
    if (TICK_DIV < 1) begin : g_bad_div
      $error("uart_rx: CLK_FREQ too low for BAUD_RATE*OVERSAMPLE");
    end
    if ((OVERSAMPLE < 8) || (OVERSAMPLE % 2 != 0)) begin : g_bad_os
      $error("uart_rx: OVERSAMPLE must be even and >= 8");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;

  state_t          state, state_next;
  logic            rx_m, rx_s;
  logic [TW-1:0]   tcnt;
  logic            tick;
  logic [SW-1:0]   scnt;
  logic [2:0]      bcnt;
  logic [7:0]      shreg;
  logic            arm;
  logic            scnt_clr, scnt_inc, bcnt_clr, shift_en, good_stop, bad_stop;

  // Synchronizer flops reset to the idle line level so reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (srst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk) begin
    if (srst)               tcnt <= '0;
    else if (tcnt == T_LAST) tcnt <= '0;
    else                    tcnt <= tcnt + TW'(1);
  end

  assign tick = (tcnt == T_LAST);

  always_ff @(posedge clk) begin
    if (srst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    scnt_clr   = 1'b0;
    scnt_inc   = 1'b0;
    bcnt_clr   = 1'b0;
    shift_en   = 1'b0;
    good_stop  = 1'b0;
    bad_stop   = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          if (arm && !rx_s) begin
            state_next = START;
            scnt_clr   = 1'b1;
          end
        end
        START: begin
          // A start bit that is no longer low at mid-bit was a glitch.
          if (scnt == S_HALF) begin
            if (!rx_s) begin
              state_next = DATA;
              scnt_clr   = 1'b1;
              bcnt_clr   = 1'b1;
            end else begin
              state_next = IDLE;
            end
          end else begin
            scnt_inc = 1'b1;
          end
        end
        DATA: begin
          if (scnt == S_LAST) begin
            shift_en = 1'b1;
            scnt_clr = 1'b1;
            if (bcnt == 3'd7) state_next = STOP;
          end else begin
            scnt_inc = 1'b1;
          end
        end
        STOP: begin
          if (scnt == S_LAST) begin
            state_next = IDLE;
            good_stop  = rx_s;
            bad_stop   = !rx_s;
          end else begin
            scnt_inc = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      scnt  <= '0;
      bcnt  <= '0;
      shreg <= '0;
    end else begin
      if (scnt_clr)      scnt <= '0;
      else if (scnt_inc) scnt <= scnt + SW'(1);
      if (bcnt_clr)      bcnt <= '0;
      else if (shift_en) bcnt <= bcnt + 3'd1;
      if (shift_en)      shreg <= {rx_s, shreg[7:1]};
    end
  end

  // arm is cleared by a framing error so a stuck-low line cannot retrigger until it idles high.
  always_ff @(posedge clk) begin
    if (srst)                          arm <= 1'b0;
    else if (bad_stop)                 arm <= 1'b0;
    else if (state == IDLE && rx_s)    arm <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      bus.data_out   <= '0;
      bus.data_valid <= 1'b0;
      bus.frame_err  <= 1'b0;
    end else begin
      bus.data_valid <= good_stop;
      bus.frame_err  <= bad_stop;
      if (good_stop) bus.data_out <= shreg;
    end
  end

  assign bus.busy  = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: drives 8N1 frames at 64 clk/bit; a negedge monitor
// pops expected bytes from a scoreboard queue on every data_valid strobe.
module tb_uart_rx;
  localparam int BIT_CLKS = 64;

  logic       clk  = 1'b0;
  logic       srst = 1'b1;
  logic       rx   = 1'b1;
  logic [1:0] dbg_state;

  uart_rx_if bus ();

  uart_rx #(.CLK_FREQ(614_400), .BAUD_RATE(9600), .OVERSAMPLE(16)) dut (
    .clk       (clk),
    .srst      (srst),
    .rx        (rx),
    .bus       (bus.master),
    .dbg_state (dbg_state)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  logic [7:0] exp_q[$];
  int         valid_cyc_q[$];
  int         ferr_exp = 0;
  int         n_cmp    = 0;
  int         n_bad    = 0;
  int         edge_cyc = 0;
  logic       prev_valid = 1'b0;
  logic       prev_ferr  = 1'b0;
  logic [7:0] exp_byte;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (bus.data_valid || bus.frame_err)
      check("strobe_exclusive", 32'(bus.data_valid & bus.frame_err), 32'd0);
    if (bus.data_valid) begin
      check("valid_one_cycle", 32'(prev_valid), 32'd0);
      valid_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: got data 0x%0h, expected no strobe (cycle %0d)", bus.data_out, cyc);
      end else begin
        exp_byte = exp_q.pop_front();
        check("data_out", 32'(bus.data_out), 32'(exp_byte));
      end
    end
    if (bus.frame_err) begin
      check("ferr_one_cycle", 32'(prev_ferr), 32'd0);
      check("frame_err_expected", 32'(ferr_exp > 0), 32'd1);
      if (ferr_exp > 0) ferr_exp--;
    end
    prev_valid = bus.data_valid;
    prev_ferr  = bus.frame_err;
  end

  // Driver tasks (all entered on a negedge)
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data_out"}, 32'(bus.data_out), 32'd0);
    check({tag, "_valid"},    32'(bus.data_valid), 32'd0);
    check({tag, "_ferr"},     32'(bus.frame_err), 32'd0);
    check({tag, "_busy"},     32'(bus.busy), 32'd0);
    check({tag, "_state"},    32'(dbg_state), 32'd0);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int rst_bit);
    rx = 1'b0;
    edge_cyc = cyc;
    idle(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (i == rst_bit) begin
        idle(BIT_CLKS / 2);
        srst = 1'b1;
        idle(1);
        srst = 1'b0;
        check_reset_outputs("srst_mid");
        idle(BIT_CLKS / 2 - 1);
      end else begin
        idle(BIT_CLKS);
      end
    end
    rx = stop_bit;
    idle(BIT_CLKS);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

  // Main stimulus
  initial begin
    int base;
    int lat;
    logic saw_busy;

    idle(4);
    check_reset_outputs("reset");
    srst = 1'b0;
    idle(10);

    // 1: single 0xA5 frame
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, -1);
    check("t1_valid_count", 32'(valid_cyc_q.size()), 32'd1);
    if (valid_cyc_q.size() >= 1) begin
      lat = valid_cyc_q[0] - edge_cyc;
      check("t1_latency_window", 32'(lat >= 600 && lat <= 620), 32'd1);
    end
    idle(BIT_CLKS);
    check("t1_busy_idle", 32'(bus.busy), 32'd0);
    check("t1_data_hold", 32'(bus.data_out), 32'hA5);

    // 2: 16-clk low glitch
    saw_busy = 1'b0;
    rx = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 16) rx = 1'b1;
      idle(1);
      saw_busy = saw_busy | bus.busy;
    end
    check("t2_busy_seen", 32'(saw_busy), 32'd1);
    check("t2_busy_dropped", 32'(bus.busy), 32'd0);
    idle(2 * BIT_CLKS);
    check("t2_data_hold", 32'(bus.data_out), 32'hA5);

    // 3: framing error, stuck-low line, then recovery
    ferr_exp = 1;
    send_frame(8'h3C, 1'b0, -1);
    idle(200);
    check("t3_ferr_seen", 32'(ferr_exp), 32'd0);
    check("t3_no_restart_low", 32'(bus.busy), 32'd0);
    check("t3_data_hold", 32'(bus.data_out), 32'hA5);
    rx = 1'b1;
    idle(2 * BIT_CLKS);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, -1);
    idle(BIT_CLKS);
    check("t3_recovered", 32'(bus.data_out), 32'h81);

    // 4: back-to-back frames
    base = valid_cyc_q.size();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h55);
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    send_frame(8'h55, 1'b1, -1);
    idle(BIT_CLKS);
    check("t4_valid_count", 32'(valid_cyc_q.size() - base), 32'd3);
    if (valid_cyc_q.size() == base + 3) begin
      check("t4_spacing_1", 32'(valid_cyc_q[base + 1] - valid_cyc_q[base]), 32'd640);
      check("t4_spacing_2", 32'(valid_cyc_q[base + 2] - valid_cyc_q[base + 1]), 32'd640);
    end

    // 5: reset during data bit 4 of 0xF0
    send_frame(8'hF0, 1'b1, 4);
    idle(2 * BIT_CLKS);
    check("t5_no_frame_busy", 32'(bus.busy), 32'd0);
    check("t5_data_reset", 32'(bus.data_out), 32'd0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, -1);
    idle(BIT_CLKS);
    check("t5_after_reset", 32'(bus.data_out), 32'h5A);

    // Final report
    check("final_exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("final_ferr_pending", 32'(ferr_exp), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
